// File: rtl/async_fifo_p.sv
// rtl/async_fifo_p.sv - dual-clock FIFO with Gray-coded pointer crossing and level flags
// Optional sticky ovf/udf error flags are built when FIFO_ERR_FLAGS_EN is defined.
module async_fifo_p #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = (1 << AW) - 4,
  parameter int AEMPTY_TH   = 4
) (
  input  logic          clkw,
  input  logic          clkr,
  input  logic          rst,
  input  logic          wreq,
  input  logic [DW-1:0] wd,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wlevel,
  input  logic          rreq,
  output logic [DW-1:0] rd,
  output logic          rvalid,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   rlevel
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic          ovf,
  output logic          udf
`endif
);

  localparam logic [AW:0] AFULL_L  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_L = (AW+1)'(AEMPTY_TH);

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DW-1:0] mem [2**AW];

  // Reset asserts asynchronously in both domains and releases on each domain's own clock.
  logic [1:0] wrst_q, rrst_q;
  logic       wrst_n, rrst_n;

  always_ff @(posedge clkw or negedge rst)
    if (!rst) wrst_q <= 2'b00;
    else      wrst_q <= {wrst_q[0], 1'b1};

  always_ff @(posedge clkr or negedge rst)
    if (!rst) rrst_q <= 2'b00;
    else      rrst_q <= {rrst_q[0], 1'b1};

  assign wrst_n = wrst_q[1];
  assign rrst_n = rrst_q[1];

  logic [AW:0] wptr_q, wgray_q, rptr_q, rgray_q;
  logic [AW:0] rg_sync_q [SYNC_STAGES];
  logic [AW:0] wg_sync_q [SYNC_STAGES];
  logic        full_q, afull_q, empty_q, aempty_q, rvalid_q;
  logic [AW:0] wlevel_q, rlevel_q;
  logic [DW-1:0] rd_q;

  logic        winc, rinc;
  logic [AW:0] wbin_d, wgray_d, rsync_g, wlevel_d;
  logic [AW:0] rbin_d, rgray_d, wsync_g, rlevel_d;

  assign winc     = wreq & ~full_q & wrst_n;
  assign wbin_d   = wptr_q + {{AW{1'b0}}, winc};
  assign wgray_d  = wbin_d ^ (wbin_d >> 1);
  assign rsync_g  = rg_sync_q[SYNC_STAGES-1];
  assign wlevel_d = wbin_d - g2b(rsync_g);

  always_ff @(posedge clkw or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q   <= '0;
      wgray_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      wlevel_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rg_sync_q[i] <= '0;
    end else begin
      wptr_q   <= wbin_d;
      wgray_q  <= wgray_d;
      // Full when the write pointer is one lap (top two Gray bits differ) ahead of the read pointer.
      full_q   <= (wgray_d == {~rsync_g[AW:AW-1], rsync_g[AW-2:0]});
      afull_q  <= (wlevel_d >= AFULL_L);
      wlevel_q <= wlevel_d;
      rg_sync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rg_sync_q[i] <= rg_sync_q[i-1];
    end
  end

  always_ff @(posedge clkw)
    if (winc) mem[wptr_q[AW-1:0]] <= wd;

  assign rinc     = rreq & ~empty_q & rrst_n;
  assign rbin_d   = rptr_q + {{AW{1'b0}}, rinc};
  assign rgray_d  = rbin_d ^ (rbin_d >> 1);
  assign wsync_g  = wg_sync_q[SYNC_STAGES-1];
  assign rlevel_d = g2b(wsync_g) - rbin_d;

  always_ff @(posedge clkr or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_q   <= '0;
      rgray_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      rlevel_q <= '0;
      rvalid_q <= 1'b0;
      rd_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wg_sync_q[i] <= '0;
    end else begin
      rptr_q   <= rbin_d;
      rgray_q  <= rgray_d;
      empty_q  <= (rgray_d == wsync_g);
      aempty_q <= (rlevel_d <= AEMPTY_L);
      rlevel_q <= rlevel_d;
      rvalid_q <= rinc;
      if (rinc) rd_q <= mem[rptr_q[AW-1:0]];
      wg_sync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wg_sync_q[i] <= wg_sync_q[i-1];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clkw or negedge wrst_n)
    if (!wrst_n) ovf_q <= 1'b0;
    else         ovf_q <= ovf_q | (wreq & full_q);

  always_ff @(posedge clkr or negedge rrst_n)
    if (!rrst_n) udf_q <= 1'b0;
    else         udf_q <= udf_q | (rreq & empty_q);

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

  assign full   = full_q;
  assign afull  = afull_q;
  assign wlevel = wlevel_q;
  assign rd     = rd_q;
  assign rvalid = rvalid_q;
  assign empty  = empty_q;
  assign aempty = aempty_q;
  assign rlevel = rlevel_q;

endmodule

// File: tb/tb_async_fifo_p.sv
// tb/tb_async_fifo_p.sv - directed self-checking bench for async_fifo_p (DW=8, AW=4)
module tb_async_fifo_p;

  logic       clkw = 1'b0, clkr = 1'b0, rst = 1'b0;
  logic       wreq = 1'b0, rreq = 1'b0;
  logic [7:0] wd = '0;
  logic       full, afull, empty, aempty, rvalid;
  logic [4:0] wlevel, rlevel;
  logic [7:0] rd;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf, udf;
`endif

  async_fifo_p #(.DW(8), .AW(4), .SYNC_STAGES(2), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
    .clkw(clkw), .clkr(clkr), .rst(rst),
    .wreq(wreq), .wd(wd), .full(full), .afull(afull), .wlevel(wlevel),
    .rreq(rreq), .rd(rd), .rvalid(rvalid), .empty(empty), .aempty(aempty), .rlevel(rlevel)
`ifdef FIFO_ERR_FLAGS_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  int rhi = 6, rlo = 7;
  always #5 clkw = ~clkw;
  always begin
    #(rhi) clkr = 1'b1;
    #(rlo) clkr = 1'b0;
  end

  int checks = 0, errors = 0;
  int rx_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wpush(input logic [7:0] d);
    @(negedge clkw);
    wreq = 1'b1;
    wd   = d;
    @(posedge clkw);
    #1;
    wreq = 1'b0;
  endtask

  task automatic rpop(output logic v, output logic [7:0] d);
    @(negedge clkr);
    rreq = 1'b1;
    @(posedge clkr);
    #1;
    rreq = 1'b0;
    v = rvalid;
    d = rd;
  endtask

  logic       v;
  logic [7:0] d;
  int         n;

  initial begin
    repeat (3) @(posedge clkw);
    #1;
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(afull), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(aempty), 1);
    check("rst_wlevel", 32'(wlevel), 0);
    check("rst_rlevel", 32'(rlevel), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rd", 32'(rd), 0);
    rst = 1'b1;
    repeat (4) @(posedge clkr);

    // Fill to full, then one dropped write.
    for (int k = 1; k <= 16; k++) begin
      wpush(8'(k));
      if (k == 11) check("afull_11", 32'(afull), 0);
      if (k == 12) begin
        check("afull_12", 32'(afull), 1);
        check("wlevel_12", 32'(wlevel), 12);
      end
      if (k == 15) check("full_15", 32'(full), 0);
      if (k == 16) begin
        check("full_16", 32'(full), 1);
        check("wlevel_16", 32'(wlevel), 16);
      end
    end
    wpush(8'hAA);
    check("full_ovr", 32'(full), 1);
    check("wlevel_ovr", 32'(wlevel), 16);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf", 32'(ovf), 1);
`endif
    repeat (6) @(posedge clkr);
    #1;
    check("rlevel_16", 32'(rlevel), 16);
    check("empty_full", 32'(empty), 0);
    check("aempty_full", 32'(aempty), 0);

    // Drain in order, then one read from empty.
    for (int k = 1; k <= 16; k++) begin
      rpop(v, d);
      check("drain_rvalid", 32'(v), 1);
      check("drain_rd", 32'(d), 32'(k));
      if (k == 11) check("aempty_11", 32'(aempty), 0);
      if (k == 12) check("aempty_12", 32'(aempty), 1);
      if (k == 16) begin
        check("empty_16", 32'(empty), 1);
        check("rlevel_0", 32'(rlevel), 0);
      end
    end
    rpop(v, d);
    check("udr_rvalid", 32'(v), 0);
    check("udr_rd_hold", 32'(d), 32'h10);
`ifdef FIFO_ERR_FLAGS_EN
    check("udf", 32'(udf), 1);
`endif
    repeat (6) @(posedge clkw);
    #1;
    check("full_clear", 32'(full), 0);
    check("wlevel_clear", 32'(wlevel), 0);
    check("afull_clear", 32'(afull), 0);

    // Slow read clock: empty must drop within SYNC_STAGES+2 read edges.
    rhi = 18;
    rlo = 19;
    repeat (2) @(posedge clkr);
    wpush(8'h5A);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clkr);
      #1;
      if (!empty) begin
        n = k;
        break;
      end
    end
    check("empty_lat_ok", 32'(n >= 1 && n <= 4), 1);
    rpop(v, d);
    check("slow_rvalid", 32'(v), 1);
    check("slow_rd", 32'(d), 32'h5A);
    check("slow_empty", 32'(empty), 1);

    // Streaming 40 words with both sides active.
    rhi = 6;
    rlo = 7;
    repeat (2) @(posedge clkr);
    fork
      begin
        int i, g;
        logic acc;
        i = 0;
        g = 0;
        while (i < 40 && g < 2000) begin
          @(negedge clkw);
          wreq = 1'b1;
          wd   = 8'(i);
          acc  = !full;
          @(posedge clkw);
          if (acc) i++;
          g++;
        end
        #1 wreq = 1'b0;
      end
      begin
        int g;
        g = 0;
        while (rx_cnt < 40 && g < 2000) begin
          @(negedge clkr);
          rreq = 1'b1;
          @(posedge clkr);
          #1;
          if (rvalid) begin
            check("stream_rd", 32'(rd), 32'(rx_cnt));
            rx_cnt++;
          end
          g++;
        end
        rreq = 1'b0;
      end
    join
    check("stream_count", 32'(rx_cnt), 40);

    // Reset mid-content: everything discarded.
    for (int k = 0; k < 8; k++) wpush(8'(8'h30 + k));
    @(negedge clkw);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_full", 32'(full), 0);
    check("mid_rst_wlevel", 32'(wlevel), 0);
    check("mid_rst_rlevel", 32'(rlevel), 0);
    check("mid_rst_rd", 32'(rd), 0);
    #1 rst = 1'b1;
    repeat (4) @(posedge clkr);
    wpush(8'h77);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clkr);
      #1;
      if (!empty) begin
        n = k;
        break;
      end
    end
    check("post_rst_nonempty", 32'(n != 0), 1);
    rpop(v, d);
    check("post_rst_rvalid", 32'(v), 1);
    check("post_rst_rd", 32'(d), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
